// File: rtl/key_event_fifo_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Values shared by the keyboard event FIFO and the modules around it.
//   KEY_DEPTH  : number of buffered keyboard bytes
//   KEY_DATA_W : width of one keyboard byte (ASCII code)
//   KEY_EMPTY  : value presented on key_data while the FIFO holds nothing
// -----------------------------------------------------------------------------
package key_pkg;

    localparam int KEY_DEPTH  = 8;
    localparam int KEY_DATA_W = 8;

    localparam logic [KEY_DATA_W-1:0] KEY_EMPTY = 8'h00;

endpackage : key_pkg

// File: rtl/key_event_fifo_sync.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Double-flop synchroniser for signals that arrive from another clock domain
// or directly from a pin. The reset value is a parameter so that a chain can
// come out of reset at its idle level and not create a false edge.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset
//   d_i     : asynchronous input
//   q_o     : synchronised output (two flops behind d_i)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule : sync_2ff

// File: rtl/key_event_fifo.sv
// -----------------------------------------------------------------------------
// key_event_fifo
// Buffers keyboard bytes between the PS/2 decoder and the CPU key register so
// that keystrokes survive a slow CPU. Everything runs on sysclk.
//
// Ports:
//   sysclk          : system clock, all state on its rising edge
//   rst_n           : asynchronous active-low reset
//   ascii_code      : byte from the decoder, stable around the strobe
//   scan_code_ready : asynchronous decoder strobe, falling edge = new byte
//   pop_toggle      : CPU-domain toggle, every level change pops one byte
//   clr_ovf         : synchronous clear of the sticky overflow flag
//   key_data        : head byte, KEY_EMPTY when nothing is stored
//   key_valid       : FIFO holds at least one byte
//   key_count       : occupancy 0..DEPTH
//   sample          : toggles once for every accepted byte
//   overflow        : sticky, set when a byte is dropped on a full FIFO
//   key_irq         : interrupt request, same as key_valid
//
// Handshake: there is no ready/backpressure. A producer event (strobe falling
// edge) is accepted whenever space exists or a pop happens in the same cycle,
// otherwise it is dropped and flagged. A consumer event (toggle change) takes
// the head byte if one exists and is otherwise ignored. The CPU must not
// toggle again before the previous pop is visible on key_data.
// -----------------------------------------------------------------------------
module key_event_fifo
    import key_pkg::*;
#(
    parameter int DEPTH  = KEY_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int DATA_W = KEY_DATA_W
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ascii_code,
    input  logic              scan_code_ready,
    input  logic              pop_toggle,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] key_data,
    output logic              key_valid,
    output logic [PTR_W:0]    key_count,
    output logic              sample,
    output logic              overflow,
    output logic              key_irq
);

    localparam int PW = PTR_W + 1;
    localparam logic [PW-1:0]     FULL_CNT  = PW'(DEPTH);
    localparam logic [DATA_W-1:0] EMPTY_VAL = DATA_W'(KEY_EMPTY);

    // ------------------------------------------------------------------
    // Synchronisers and edge detection
    // ------------------------------------------------------------------
    logic s2;
    logic s3_q;
    logic p2;
    logic p3_q;

    // The strobe idles high, so its chain resets high: releasing reset
    // while the decoder is idle must not look like a falling edge.
    sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync_scr (
        .clk_i  (sysclk),
        .rst_ni (rst_n),
        .d_i    (scan_code_ready),
        .q_o    (s2)
    );

    sync_2ff #(.W(1), .RST_VAL(1'b0)) u_sync_pop (
        .clk_i  (sysclk),
        .rst_ni (rst_n),
        .d_i    (pop_toggle),
        .q_o    (p2)
    );

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            s3_q <= 1'b1;
            p3_q <= 1'b0;
        end else begin
            s3_q <= s2;
            p3_q <= p2;
        end
    end

    logic push_req;
    logic pop_req;

    assign push_req = s3_q & ~s2;
    assign pop_req  = p2 ^ p3_q;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     count_q,  count_d;
    logic [DATA_W-1:0] key_data_q, key_data_d;
    logic              key_valid_q, key_valid_d;
    logic              sample_q, sample_d;
    logic              overflow_q, overflow_d;

    logic do_push;
    logic do_pop;
    logic drop;

    always_comb begin
        do_pop      = 1'b0;
        do_push     = 1'b0;
        drop        = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        sample_d    = sample_q;
        overflow_d  = overflow_q;
        key_data_d  = EMPTY_VAL;
        key_valid_d = 1'b0;

        // A pop only happens when something is stored. A push into a full
        // FIFO still succeeds when a pop frees the head in the same cycle.
        do_pop  = pop_req && (count_q != '0);
        do_push = push_req && ((count_q != FULL_CNT) || do_pop);
        drop    = push_req && !do_push;

        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + PW'(do_push) - PW'(do_pop);

        if (do_push) begin
            sample_d = ~sample_q;
        end

        // Set wins over clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        key_valid_d = (count_d != '0);

        // When the new head is the slot being written this cycle (push into
        // empty, or push+pop with one entry) the array is not updated yet,
        // so forward the incoming byte.
        if (count_d == '0) begin
            key_data_d = EMPTY_VAL;
        end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            key_data_d = ascii_code;
        end else begin
            key_data_d = mem_q[rd_ptr_d[PTR_W-1:0]];
        end
    end

    // Storage has no reset; only entries below the write pointer are read.
    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= ascii_code;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            key_data_q  <= EMPTY_VAL;
            key_valid_q <= 1'b0;
            sample_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            key_data_q  <= key_data_d;
            key_valid_q <= key_valid_d;
            sample_q    <= sample_d;
            overflow_q  <= overflow_d;
        end
    end

    assign key_data  = key_data_q;
    assign key_valid = key_valid_q;
    assign key_count = count_q;
    assign sample    = sample_q;
    assign overflow  = overflow_q;
    assign key_irq   = key_valid_q;

endmodule : key_event_fifo

// File: doc/key_event_fifo.md
Name: key_event_fifo

Overview:
- Buffers keyboard bytes between the PS/2 keyboard decoder and the CPU memory-mapped key register.
- Replaces the single-byte key_reg/sample capture, which loses keystrokes when the CPU is slower than the typist.
- Runs entirely on sysclk. Synchronises the decoder's scan_code_ready strobe and the CPU-side pop toggle.
- Exposes the head byte, occupancy, a sticky overflow flag and an interrupt request to the datapath.

Parameters:
- DEPTH, 8, FIFO entries. Power of two, minimum 2.
- PTR_W, 3, log2(DEPTH). Pointers are PTR_W+1 bits wide (wrap bit).
- DATA_W, 8, byte width (ASCII code).

Ports:
- sysclk  input  1  system clock; all state on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ascii_code  input  DATA_W  byte from the keyboard decoder. Held stable at least 4 sysclk after scan_code_ready falls.
- scan_code_ready  input  1  asynchronous decoder strobe; its falling edge marks a new byte.
- pop_toggle  input  1  from the CPU clock domain. Each change of level requests one pop.
- clr_ovf  input  1  synchronous clear of the overflow flag. Level, sysclk domain.
- key_data  output  DATA_W  head byte; 8'h00 when empty.
- key_valid  output  1  FIFO not empty.
- key_count  output  PTR_W+1  occupancy, 0..DEPTH.
- sample  output  1  toggles once per accepted push; drives the existing sample input of the memory block.
- overflow  output  1  sticky; set when a byte is dropped.
- key_irq  output  1  equals key_valid; intended for the scheduler interrupt path.

Behaviour:
- Reset (rst_n=0, any time, takes effect immediately):
  - pointers and count = 0; key_data = 8'h00; key_valid = 0; sample = 0; overflow = 0.
  - Synchroniser flops cleared to 0, except the scan_code_ready chain, which resets to 1 so a release from reset never fakes an edge.
  - The pop edge register resets to 0. Storage array is not reset.
- Push path:
  - scan_code_ready passes through 2 flops (s1, s2) and a delay flop s3.
  - push_req = s3 & ~s2 (falling edge), a one-cycle pulse.
  - On push_req, ascii_code is sampled directly in the same cycle.
- Pop path:
  - pop_toggle passes through 2 flops (p1, p2) and a delay flop p3.
  - pop_req = p2 ^ p3. Every transition is one pop.
- Per-cycle resolution, using count before the edge:
  - push_req only, count<DEPTH: write mem[wr_ptr], wr_ptr++, count++, sample toggles.
  - push_req only, count==DEPTH: byte dropped, overflow<=1, pointers and sample unchanged.
  - pop_req only, count>0: rd_ptr++, count--.
  - pop_req only, count==0: ignored, no state change.
  - push_req and pop_req, 0<count<=DEPTH: both performed, count unchanged, sample toggles, no overflow (including when full).
  - push_req and pop_req, count==0: push performed, pop ignored, count becomes 1.
- Pointers wrap modulo 2*DEPTH. Index = low PTR_W bits.
- Outputs are registered:
  - key_data <= (next count==0) ? 0 : mem[next rd_ptr]. This includes write-through when pushing into an empty FIFO.
  - key_valid and key_count follow the next-state count.
- Latency:
  - From the scan_code_ready falling edge at the pin to key_valid=1 and key_data valid: 3-4 sysclk.
  - From a pop_toggle change to key_data advancing: 3-4 sysclk.
- The CPU must not issue a second pop toggle until the first has taken effect; one CPU clock (64 sysclk) guarantees this.
- overflow is cleared only by clr_ovf=1 or reset. If clr_ovf and a drop occur in the same cycle, set wins.
- key_irq = key_valid (combinational from the registered flag).

Decomposition:
- Shared package key_pkg holds:
  - KEY_DEPTH = 8, KEY_DATA_W = 8
  - the empty-value constant KEY_EMPTY = 8'h00
- Natural sub-module: sync_2ff, a parameterised-width double-flop synchroniser with a reset value parameter. It is instantiated twice.
- FIFO storage and control stay in key_event_fifo.

Test Plan:
- Reset released with scan_code_ready=1 and pop_toggle=0 -> key_valid=0, key_data=00, key_count=0, sample=0, overflow=0. No spurious push within 10 cycles.
- Push 8'h41 (scan_code_ready 1→0, held low 10 cycles) -> within 4 sysclk: key_valid=1, key_data=41, key_count=1, sample=1.
- Push 41,42,43, then toggle pop_toggle 3 times at 64-cycle spacing -> key_data reads 41, 42, 43, then 00. key_valid drops after the 3rd pop and key_count returns to 0.
- Push 9 bytes 30..38 with no pop -> key_count=8, overflow=1, sample toggled 8 times. Pops return 30..37; 38 is lost. clr_ovf pulse -> overflow=0.
- FIFO full (8 bytes), push 8'h5A and pop aligned to the same cycle -> key_count stays 8, overflow stays 0, 5A is the last entry out.
- Assert rst_n=0 mid-stream with 5 entries stored -> all outputs return to their reset values asynchronously, before the next sysclk edge. After release, a fresh push of 8'h31 reads back as 31 with key_count=1.
